// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking access controller.
package parking_pkg;

  localparam int unsigned N_SPOTS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GATE  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_ENTRY = 1'b0,
    REQ_EXIT  = 1'b1
  } req_t;

endpackage

// File: rtl/parking_access_controller_allocator.sv
// Find-first-zero over the occupancy bitmap: one-hot lowest free spot.
module park_spot_allocator #(
  parameter int unsigned N_SPOTS = 8
) (
  input  logic [N_SPOTS-1:0] occupancy,
  output logic [N_SPOTS-1:0] free_spot_c,
  output logic               none_free_c
);

  logic found;

  always_comb begin
    free_spot_c = '0;
    found       = 1'b0;
    for (int i = 0; i < int'(N_SPOTS); i++) begin
      if (!occupancy[i] && !found) begin
        free_spot_c[i] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign none_free_c = ~found;

endmodule

// File: rtl/parking_access_controller.sv
// Arbitrates entry/exit gates over the shared occupancy bitmap and times the gate.
module parking_access_controller
  import parking_pkg::*;
#(
  parameter int unsigned N_SPOTS     = N_SPOTS_DEF,
  parameter int unsigned GATE_CYCLES = 4,
  parameter int unsigned CNT_W       = $clog2(N_SPOTS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic [N_SPOTS-1:0] exit_location,
  output logic               entry_ack,
  output logic               entry_full,
  output logic [N_SPOTS-1:0] entry_location,
  output logic               exit_ack,
  output logic               exit_err,
  output logic               gate_open,
  output logic [N_SPOTS-1:0] occupancy,
  output logic [CNT_W-1:0]   free_count,
  output logic               full,
  output logic               empty
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);

  state_t             state, state_d;
  req_t               last_served, last_served_d;
  logic [N_SPOTS-1:0] grant_mask, grant_mask_d;
  logic               grant_valid, grant_valid_d;
  logic [GATE_W-1:0]  gate_cnt, gate_cnt_d;

  logic               entry_ack_d, entry_full_d, exit_ack_d, exit_err_d, gate_open_d;
  logic [N_SPOTS-1:0] entry_location_d, occupancy_d;
  logic [CNT_W-1:0]   free_count_d;
  logic               full_d, empty_d;

  logic [N_SPOTS-1:0] free_spot_c;
  logic               none_free_c;
  logic               exit_ok_c;
  logic               serve_entry;

  park_spot_allocator #(.N_SPOTS(N_SPOTS)) u_alloc (
    .occupancy   (occupancy),
    .free_spot_c (free_spot_c),
    .none_free_c (none_free_c)
  );

  // Exit is valid only for a single set bit that is currently occupied.
  assign exit_ok_c = (exit_location != '0)
                   && ((exit_location & (exit_location - N_SPOTS'(1))) == '0)
                   && ((exit_location & occupancy) == exit_location);

  // Acks are registered on the IDLE edge so they are high during GRANT;
  // the occupancy toggle is applied on the GRANT edge. last_served then names the side in flight.
  always_comb begin
    state_d          = state;
    last_served_d    = last_served;
    grant_mask_d     = grant_mask;
    grant_valid_d    = grant_valid;
    gate_cnt_d       = gate_cnt;
    occupancy_d      = occupancy;
    free_count_d     = free_count;
    full_d           = full;
    empty_d          = empty;
    entry_ack_d      = 1'b0;
    entry_full_d     = 1'b0;
    entry_location_d = '0;
    exit_ack_d       = 1'b0;
    exit_err_d       = 1'b0;
    gate_open_d      = 1'b0;
    serve_entry      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (entry_req || exit_req) begin
          serve_entry = entry_req && (!exit_req || (last_served == REQ_EXIT));
          state_d     = ST_GRANT;
          if (serve_entry) begin
            last_served_d    = REQ_ENTRY;
            entry_ack_d      = 1'b1;
            entry_full_d     = none_free_c;
            entry_location_d = free_spot_c;
            grant_mask_d     = free_spot_c;
            grant_valid_d    = !none_free_c;
          end else begin
            last_served_d    = REQ_EXIT;
            exit_ack_d       = 1'b1;
            exit_err_d       = !exit_ok_c;
            grant_mask_d     = exit_location;
            grant_valid_d    = exit_ok_c;
          end
        end
      end
      ST_GRANT: begin
        if (grant_valid) begin
          occupancy_d  = occupancy ^ grant_mask;
          free_count_d = (last_served == REQ_ENTRY) ? free_count - CNT_W'(1)
                                                    : free_count + CNT_W'(1);
          full_d       = (free_count_d == '0);
          empty_d      = (free_count_d == CNT_W'(N_SPOTS));
          gate_cnt_d   = GATE_W'(GATE_CYCLES);
          gate_open_d  = 1'b1;
          state_d      = ST_GATE;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (gate_cnt == GATE_W'(1)) begin
          state_d     = ST_IDLE;
        end else begin
          gate_cnt_d  = gate_cnt - GATE_W'(1);
          gate_open_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      last_served    <= REQ_EXIT;
      grant_mask     <= '0;
      grant_valid    <= 1'b0;
      gate_cnt       <= '0;
      occupancy      <= '0;
      free_count     <= CNT_W'(N_SPOTS);
      full           <= 1'b0;
      empty          <= 1'b1;
      entry_ack      <= 1'b0;
      entry_full     <= 1'b0;
      entry_location <= '0;
      exit_ack       <= 1'b0;
      exit_err       <= 1'b0;
      gate_open      <= 1'b0;
    end else begin
      state          <= state_d;
      last_served    <= last_served_d;
      grant_mask     <= grant_mask_d;
      grant_valid    <= grant_valid_d;
      gate_cnt       <= gate_cnt_d;
      occupancy      <= occupancy_d;
      free_count     <= free_count_d;
      full           <= full_d;
      empty          <= empty_d;
      entry_ack      <= entry_ack_d;
      entry_full     <= entry_full_d;
      entry_location <= entry_location_d;
      exit_ack       <= exit_ack_d;
      exit_err       <= exit_err_d;
      gate_open      <= gate_open_d;
    end
  end

endmodule

// File: doc/parking_access_controller.md
Name: parking_access_controller

Overview:
- Sequences the parking lot's shared occupancy register between two requesters, the entry gate and the exit gate.
- Entry: allocates the lowest-index free spot. Exit: releases a named spot.
- Each grant toggles one occupancy bit (next occupancy = occupancy XOR one-hot spot) and then holds the gate open for a fixed time.
- Sits between the gate sensor logic and the display/status logic.

Parameters:
- N_SPOTS, 8, number of parking spots; occupancy width; bit i = 1 means spot i occupied.
- GATE_CYCLES, 4, cycles gate_open stays high after a successful grant; must be >= 1.
- CNT_W, $clog2(N_SPOTS+1) (4 at default), width of free_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- entry_req  input  1  level request from entry gate; held until entry_ack.
- exit_req  input  1  level request from exit gate; held until exit_ack.
- exit_location  input  N_SPOTS  one-hot spot being vacated; stable while exit_req is high.
- entry_ack  output  1  one-cycle pulse completing an entry request.
- entry_full  output  1  valid with entry_ack; 1 = lot full, request rejected.
- entry_location  output  N_SPOTS  one-hot allocated spot; valid with entry_ack; 0 when rejected.
- exit_ack  output  1  one-cycle pulse completing an exit request.
- exit_err  output  1  valid with exit_ack; 1 = exit_location not one-hot or spot not occupied.
- gate_open  output  1  high for GATE_CYCLES cycles after a successful grant.
- occupancy  output  N_SPOTS  current occupancy bitmap (registered).
- free_count  output  CNT_W  number of zero bits in occupancy (registered).
- full  output  1  free_count == 0.
- empty  output  1  free_count == N_SPOTS.

Behaviour:
- Reset values (async, immediate): state IDLE; occupancy 0; free_count N_SPOTS; empty 1; full 0.
  - All acks, flags, entry_location, gate_open 0.
  - last_served = EXIT, so the first tie goes to entry.
- All outputs are registered.
- States: IDLE, GRANT, GATE.
- IDLE:
  - No request: stay.
  - One request: latch it and go to GRANT.
  - Both requests: serve the side not in last_served, then update last_served.
- GRANT (exactly one cycle), pulse the matching ack:
  - Entry, not full: entry_location = lowest-index 0 bit of occupancy; occupancy ^= entry_location; free_count -1; go to GATE.
  - Entry, full: entry_full = 1, entry_location = 0, occupancy unchanged; back to IDLE.
  - Exit, valid (exactly one bit set, and that bit occupied): occupancy ^= exit_location; free_count +1; go to GATE.
  - Exit, invalid: exit_err = 1, no change; back to IDLE.
- Latency: request sampled at IDLE edge t; ack high in cycle t+1; new occupancy visible from cycle t+2.
- GATE: gate_open = 1 for exactly GATE_CYCLES cycles, counter counting down, then IDLE.
  - Requests arriving during GRANT or GATE are not sampled and wait; none are lost.
- A req still high on return to IDLE is treated as a new request. Requesters drop req the cycle after their ack.
- full and empty are updated in the same cycle as occupancy.
- Reset asserted mid-GRANT or mid-GATE: everything returns to reset values and the pending grant is discarded.
- occupancy never changes except in a valid GRANT.

Decomposition:
- Shared package parking_pkg holds:
  - N_SPOTS default;
  - state encoding constants ST_IDLE / ST_GRANT / ST_GATE;
  - requester encoding REQ_ENTRY / REQ_EXIT.
- Sub-module park_spot_allocator: combinational find-first-zero over occupancy. Outputs a one-hot free spot plus a none_free flag.

Test Plan:
- Reset, then entry_req held -> entry_ack at cycle 2 with entry_location=8'h01; occupancy=8'h01, free_count=7; gate_open high exactly 4 cycles.
- Occupancy 8'b0000_0111, entry_req -> entry_location=8'h08, occupancy=8'h0F, free_count=4.
- Lot full (8'hFF), entry_req -> entry_ack with entry_full=1, entry_location=0, no gate_open, occupancy stays 8'hFF.
- Occupancy 8'h0F, exit_location=8'h04 -> exit_ack, exit_err=0, occupancy=8'h0B. Then exit_location=8'h10 (unoccupied) or 8'h06 (not one-hot) -> exit_err=1, occupancy unchanged.
- entry_req and exit_req high together, repeatedly, from reset -> grants alternate entry, exit, entry, with no grant inside any gate_open window.
- Reset asserted during the GATE count -> gate_open, occupancy, acks cleared immediately; free_count=8, empty=1.
